// File: rtl/f8_mem_pkg.sv
// Shared types and helpers for the f8 memory responder: FSM state encoding,
// port byte widths and the address decode used by every CPU-side port.
package f8_mem_pkg;

  typedef enum logic {
    MEM_INIT  = 1'b0,
    MEM_READY = 1'b1
  } memstate_t;

  localparam int FETCH_BYTES = 3;
  localparam int DATA_BYTES  = 2;

  // A byte is mapped when its offset from base, taken modulo 2^16, lands
  // inside the RAM. The modular subtraction makes a window that straddles
  // 16'hFFFF decode correctly.
  function automatic logic byte_mapped(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input int unsigned size);
    logic [15:0] off;
    off = addr - base;
    return {16'd0, off} < size;
  endfunction

endpackage

// File: rtl/f8_byte_ram.sv
// Byte-wide RAM with five combinational read ports and three prioritised
// write ports. Write port 0 has the highest priority. Reads see the value
// being written on the same edge (write-first), so the registered read in
// the parent returns the new byte.
module f8_byte_ram
  import f8_mem_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  localparam int AW = $clog2(MEM_BYTES),
  localparam int NRD = FETCH_BYTES + DATA_BYTES,
  localparam int NWR = 3
) (
  input  logic              clk,
  input  logic [NRD*AW-1:0] rd_idx,
  output logic [NRD*8-1:0]  rd_data,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_idx,
  input  logic [NWR*8-1:0]  wr_data
);

  logic [7:0] mem_q [MEM_BYTES];

  // Commit writes lowest priority first so a higher-priority port to the
  // same byte overrides it.
  always_ff @(posedge clk) begin
    for (int p = NWR - 1; p >= 0; p--) begin
      if (wr_en[p]) begin
        mem_q[wr_idx[p*AW +: AW]] <= wr_data[p*8 +: 8];
      end
    end
  end

  // Read each port from storage, then let any same-edge write to that byte
  // replace it, again applying ports from lowest to highest priority.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_data[r*8 +: 8] = mem_q[rd_idx[r*AW +: AW]];
      for (int p = NWR - 1; p >= 0; p--) begin
        if (wr_en[p] && (wr_idx[p*AW +: AW] == rd_idx[r*AW +: AW])) begin
          rd_data[r*8 +: 8] = wr_data[p*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/f8_mem_responder.sv
// Memory-side responder for the f8 core: 3-byte instruction fetch, 16-bit
// data read, byte-enabled 16-bit data write and a byte load port, all served
// from one on-chip RAM. Holds the init/clear FSM, address decode, registered
// read data and the sticky bus error flag.
module f8_mem_responder
  import f8_mem_pkg::*;
#(
  parameter logic [15:0] BASE           = 16'h4000,
  parameter int          MEM_BYTES      = 4096,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] iread_addr,
  output logic [23:0] iread_data,
  output logic        ivalid,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  output logic        ready,
  output logic        bus_err
);

  localparam int AW  = $clog2(MEM_BYTES);
  localparam int NRD = FETCH_BYTES + DATA_BYTES;
  localparam int NWR = 3;

  // RAM index of a byte address; only meaningful when the byte is mapped.
  function automatic logic [AW-1:0] ram_index(input logic [15:0] b);
    logic [15:0] off;
    off = b - BASE;
    return off[AW-1:0];
  endfunction

  memstate_t         state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [23:0]       iread_data_q, iread_data_d;
  logic [15:0]       dread_data_q, dread_data_d;
  logic              ivalid_q, ivalid_d;
  logic              bus_err_q, bus_err_d;

  logic              clr_we;
  logic              wr_active;
  logic              rd_active;
  logic              wr_err;
  logic [15:0]       rd_addr [NRD];
  logic [NRD-1:0]    rd_map;
  logic [15:0]       wr_hi_addr;
  logic [NRD*AW-1:0] ram_rd_idx;
  logic [NRD*8-1:0]  ram_rd_data;
  logic [NWR-1:0]    ram_wr_en;
  logic [NWR*AW-1:0] ram_wr_idx;
  logic [NWR*8-1:0]  ram_wr_data;

  // State and datapath registers; reset is folded into the _d logic.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    clr_cnt_q    <= clr_cnt_d;
    iread_data_q <= iread_data_d;
    dread_data_q <= dread_data_d;
    ivalid_q     <= ivalid_d;
    bus_err_q    <= bus_err_d;
  end

  // Next state: reset always restarts in INIT; INIT walks the clear counter
  // and leaves on the edge that clears the last byte (or at once if no clear).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (reset) begin
      state_d   = MEM_INIT;
      clr_cnt_d = '0;
    end else if (state_q == MEM_INIT) begin
      if (!CLEAR_ON_RESET || (clr_cnt_q == AW'(MEM_BYTES - 1))) begin
        state_d = MEM_READY;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  // FSM outputs. Reads are live on every edge that lands in READY, including
  // the transition edge, so ivalid rises together with ready. CPU writes and
  // loads only commit while already in READY.
  always_comb begin
    ready     = (state_q == MEM_READY);
    clr_we    = (state_q == MEM_INIT) && CLEAR_ON_RESET && !reset;
    wr_active = (state_q == MEM_READY) && !reset;
    rd_active = (state_d == MEM_READY);
  end

  // Read-side address generation and decode for the 3 fetch and 2 data bytes.
  always_comb begin
    rd_addr[0] = iread_addr;
    rd_addr[1] = iread_addr + 16'd1;
    rd_addr[2] = iread_addr + 16'd2;
    rd_addr[3] = dread_addr;
    rd_addr[4] = dread_addr + 16'd1;
    rd_map     = '0;
    ram_rd_idx = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_map[r]                = byte_mapped(rd_addr[r], BASE, MEM_BYTES);
      ram_rd_idx[r*AW +: AW]   = ram_index(rd_addr[r]);
    end
  end

  // Write ports: 0 = clear (INIT) or load port, 1 = data high byte,
  // 2 = data low byte. Unmapped CPU bytes are dropped and flagged.
  always_comb begin
    ram_wr_en   = '0;
    ram_wr_idx  = '0;
    ram_wr_data = '0;
    wr_err      = 1'b0;
    wr_hi_addr  = dwrite_addr + 16'd1;
    if (clr_we) begin
      ram_wr_en[0]          = 1'b1;
      ram_wr_idx[0 +: AW]   = clr_cnt_q;
      ram_wr_data[0 +: 8]   = 8'h00;
    end else if (wr_active && load_en && byte_mapped(load_addr, BASE, MEM_BYTES)) begin
      ram_wr_en[0]          = 1'b1;
      ram_wr_idx[0 +: AW]   = ram_index(load_addr);
      ram_wr_data[0 +: 8]   = load_data;
    end
    if (wr_active && dwrite_en[1]) begin
      if (byte_mapped(wr_hi_addr, BASE, MEM_BYTES)) begin
        ram_wr_en[1]          = 1'b1;
        ram_wr_idx[AW +: AW]  = ram_index(wr_hi_addr);
        ram_wr_data[8 +: 8]   = dwrite_data[15:8];
      end else begin
        wr_err = 1'b1;
      end
    end
    if (wr_active && dwrite_en[0]) begin
      if (byte_mapped(dwrite_addr, BASE, MEM_BYTES)) begin
        ram_wr_en[2]            = 1'b1;
        ram_wr_idx[2*AW +: AW]  = ram_index(dwrite_addr);
        ram_wr_data[16 +: 8]    = dwrite_data[7:0];
      end else begin
        wr_err = 1'b1;
      end
    end
  end

  // Registered read data with unmapped bytes forced to zero, and the sticky
  // bus error that only reset clears.
  always_comb begin
    iread_data_d = '0;
    dread_data_d = '0;
    ivalid_d     = rd_active;
    bus_err_d    = bus_err_q;
    if (rd_active) begin
      for (int r = 0; r < FETCH_BYTES; r++) begin
        iread_data_d[r*8 +: 8] = rd_map[r] ? ram_rd_data[r*8 +: 8] : 8'h00;
      end
      for (int r = 0; r < DATA_BYTES; r++) begin
        dread_data_d[r*8 +: 8] = rd_map[FETCH_BYTES + r] ?
                                 ram_rd_data[(FETCH_BYTES + r)*8 +: 8] : 8'h00;
      end
      if (!(&rd_map)) begin
        bus_err_d = 1'b1;
      end
    end
    if (wr_err) begin
      bus_err_d = 1'b1;
    end
    if (reset) begin
      bus_err_d = 1'b0;
    end
  end

  f8_byte_ram #(
    .MEM_BYTES (MEM_BYTES)
  ) u_ram (
    .clk     (clk),
    .rd_idx  (ram_rd_idx),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_idx  (ram_wr_idx),
    .wr_data (ram_wr_data)
  );

  assign iread_data = iread_data_q;
  assign dread_data = dread_data_q;
  assign ivalid     = ivalid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_f8_mem_responder.sv
// Bench for f8_mem_responder (BASE=16'h4000, MEM_BYTES=256, clear on reset).
// A behavioural byte-memory model predicts each edge's outputs into a queue;
// each scenario task pops and compares them, plus fixed expected constants.
module tb_f8_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] iread_addr;
  logic [23:0] iread_data;
  logic        ivalid;
  logic [15:0] dread_addr;
  logic [15:0] dread_data;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic [1:0]  dwrite_en;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic        ready;
  logic        bus_err;

  f8_mem_responder #(
    .BASE           (16'h4000),
    .MEM_BYTES      (256),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iread_addr  (iread_addr),
    .iread_data  (iread_data),
    .ivalid      (ivalid),
    .dread_addr  (dread_addr),
    .dread_data  (dread_data),
    .dwrite_addr (dwrite_addr),
    .dwrite_data (dwrite_data),
    .dwrite_en   (dwrite_en),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .ready       (ready),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] i;
    logic [15:0] d;
    logic        iv;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_mem [256];
  bit         m_init = 1'b1;
  int         m_cnt  = 0;
  bit         m_err  = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  function automatic bit m_mapped(input logic [15:0] b);
    logic [15:0] off;
    off = b - 16'h4000;
    return off < 16'd256;
  endfunction

  function automatic logic [7:0] m_rd(input logic [15:0] b);
    logic [15:0] off;
    off = b - 16'h4000;
    if (m_mapped(b)) return m_mem[off[7:0]];
    return 8'h00;
  endfunction

  task automatic m_wr(input logic [15:0] b, input logic [7:0] v);
    logic [15:0] off;
    off = b - 16'h4000;
    m_mem[off[7:0]] = v;
  endtask

  // Predict the outputs after the coming edge, queue them, then take the edge.
  task automatic drive_cycle();
    exp_t e;
    logic [15:0] a1, a2, d1, w1;
    e  = '0;
    a1 = iread_addr + 16'd1;
    a2 = iread_addr + 16'd2;
    d1 = dread_addr + 16'd1;
    w1 = dwrite_addr + 16'd1;
    if (reset) begin
      m_init = 1'b1;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      if (m_init) begin
        m_mem[m_cnt] = 8'h00;
        if (m_cnt == 255) m_init = 1'b0;
        else m_cnt++;
      end else begin
        if (dwrite_en[0]) begin
          if (m_mapped(dwrite_addr)) m_wr(dwrite_addr, dwrite_data[7:0]);
          else m_err = 1'b1;
        end
        if (dwrite_en[1]) begin
          if (m_mapped(w1)) m_wr(w1, dwrite_data[15:8]);
          else m_err = 1'b1;
        end
        if (load_en && m_mapped(load_addr)) m_wr(load_addr, load_data);
      end
      if (!m_init) begin
        e.i   = {m_rd(a2), m_rd(a1), m_rd(iread_addr)};
        e.d   = {m_rd(d1), m_rd(dread_addr)};
        e.iv  = 1'b1;
        e.rdy = 1'b1;
        if (!m_mapped(iread_addr) || !m_mapped(a1) || !m_mapped(a2) ||
            !m_mapped(dread_addr) || !m_mapped(d1)) m_err = 1'b1;
      end
      e.err = m_err;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iread_addr  = 16'h4000;
    dread_addr  = 16'h4000;
    dwrite_addr = 16'h4000;
    dwrite_data = 16'h0000;
    dwrite_en   = 2'b00;
    load_en     = 1'b0;
    load_addr   = 16'h4000;
    load_data   = 8'h00;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_cycle();
      e = sb_q.pop_front();
      checks++;
      if ({iread_data, dread_data, ivalid, ready, bus_err} !== 43'd0) begin
        failures++;
        $display("FAIL reset_outputs got i=%h d=%h iv=%b rdy=%b err=%b want all zero",
                 iread_data, dread_data, ivalid, ready, bus_err);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int low;
    low = 0;
    reset = 1'b0;
    for (int k = 0; k < 256; k++) begin
      drive_cycle();
      e = sb_q.pop_front();
      if (ready === 1'b0) low++;
      checks++;
      if (ready !== e.rdy) begin
        failures++;
        $display("FAIL clear_ready cycle %0d got=%b want=%b", k, ready, e.rdy);
      end
    end
    checks++;
    if (low !== 255) begin
      failures++;
      $display("FAIL clear_len got=%0d want=255 low cycles after reset release", low);
    end
    checks++;
    if ({ready, ivalid} !== 2'b11 || iread_data !== 24'h000000) begin
      failures++;
      $display("FAIL clear_done got rdy=%b iv=%b i=%h want 1 1 000000", ready, ivalid, iread_data);
    end
  endtask

  task automatic test_preset_clear();
    exp_t e;
    int low;
    for (int k = 0; k < 256; k++) begin
      load_en   = 1'b1;
      load_addr = 16'h4000 + 16'(k);
      load_data = 8'hFF;
      drive_cycle();
      e = sb_q.pop_front();
      checks++;
      if (dread_data !== e.d) begin
        failures++;
        $display("FAIL preset_dread k=%0d got=%h want=%h", k, dread_data, e.d);
      end
    end
    load_en = 1'b0;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (iread_data !== 24'hFFFFFF || iread_data !== e.i) begin
      failures++;
      $display("FAIL preset_fetch got=%h want=FFFFFF", iread_data);
    end
    low = 0;
    reset = 1'b1;
    drive_cycle();
    e = sb_q.pop_front();
    if (ready === 1'b0) low++;
    reset = 1'b0;
    for (int k = 0; k < 256; k++) begin
      drive_cycle();
      e = sb_q.pop_front();
      if (ready === 1'b0) low++;
    end
    checks++;
    if (low !== 256) begin
      failures++;
      $display("FAIL preset_clear_len got=%0d want=256", low);
    end
    checks++;
    if (iread_data !== 24'h000000 || dread_data !== 16'h0000 || ready !== 1'b1 || ivalid !== 1'b1) begin
      failures++;
      $display("FAIL preset_cleared got i=%h d=%h rdy=%b iv=%b want 000000 0000 1 1",
               iread_data, dread_data, ready, ivalid);
    end
  endtask

  task automatic test_load_fetch();
    exp_t e;
    logic [7:0] bytes [3];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
    iread_addr = 16'h4080;
    for (int k = 0; k < 3; k++) begin
      load_en   = 1'b1;
      load_addr = 16'h4000 + 16'(k);
      load_data = bytes[k];
      drive_cycle();
      e = sb_q.pop_front();
    end
    load_en    = 1'b0;
    iread_addr = 16'h4000;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (iread_data !== 24'h563412 || ivalid !== 1'b1) begin
      failures++;
      $display("FAIL load_fetch got=%h iv=%b want=563412 iv=1", iread_data, ivalid);
    end
    checks++;
    if (iread_data !== e.i) begin
      failures++;
      $display("FAIL load_fetch_model got=%h want=%h", iread_data, e.i);
    end
  endtask

  task automatic test_byte_enables();
    exp_t e;
    dwrite_addr = 16'h4010;
    dwrite_data = 16'hBEEF;
    dread_addr  = 16'h4010;
    dwrite_en   = 2'b01;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== e.d) begin
      failures++;
      $display("FAIL be_lo_fwd got=%h want=%h", dread_data, e.d);
    end
    dwrite_en = 2'b00;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== 16'h00EF) begin
      failures++;
      $display("FAIL be_lo got=%h want=00EF", dread_data);
    end
    dwrite_en = 2'b10;
    drive_cycle();
    e = sb_q.pop_front();
    dwrite_en = 2'b00;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL be_hi got=%h want=BEEF", dread_data);
    end
  endtask

  task automatic test_forwarding();
    exp_t e;
    dwrite_addr = 16'h4020;
    dwrite_data = 16'hA55A;
    dwrite_en   = 2'b11;
    dread_addr  = 16'h4021;
    iread_addr  = 16'h401F;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== 16'h00A5) begin
      failures++;
      $display("FAIL fwd_dread got=%h want=00A5", dread_data);
    end
    checks++;
    if (iread_data !== 24'hA55A00) begin
      failures++;
      $display("FAIL fwd_fetch got=%h want=A55A00", iread_data);
    end
    // load port and high data byte hit 16'h4030 on the same edge
    load_en     = 1'b1;
    load_addr   = 16'h4030;
    load_data   = 8'h77;
    dwrite_addr = 16'h402F;
    dwrite_data = 16'h1122;
    dwrite_en   = 2'b11;
    dread_addr  = 16'h402F;
    iread_addr  = 16'h4030;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== 16'h7722 || iread_data !== 24'h000077) begin
      failures++;
      $display("FAIL fwd_collide got d=%h i=%h want d=7722 i=000077", dread_data, iread_data);
    end
    idle_inputs();
    dread_addr = 16'h402F;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== 16'h7722 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL collide_stored got d=%h err=%b want d=7722 err=0", dread_data, bus_err);
    end
  endtask

  task automatic test_decode();
    exp_t e;
    idle_inputs();
    load_en   = 1'b1;
    load_addr = 16'h3000;
    load_data = 8'h55;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL load_unmapped_err got=%b want=0", bus_err);
    end
    load_addr = 16'h40FF;
    load_data = 8'hAB;
    drive_cycle();
    e = sb_q.pop_front();
    load_en    = 1'b0;
    iread_addr = 16'h40FF;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (iread_data !== 24'h0000AB || bus_err !== 1'b1) begin
      failures++;
      $display("FAIL decode_fetch got i=%h err=%b want i=0000AB err=1", iread_data, bus_err);
    end
    iread_addr  = 16'h4000;
    dwrite_addr = 16'h3FFF;
    dwrite_data = 16'h00EE;
    dwrite_en   = 2'b01;
    drive_cycle();
    e = sb_q.pop_front();
    dwrite_en  = 2'b00;
    dread_addr = 16'h4000;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== 16'h3412) begin
      failures++;
      $display("FAIL unmapped_write got=%h want=3412", dread_data);
    end
    dread_addr = 16'h3FFF;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (dread_data !== 16'h1200 || dread_data !== e.d) begin
      failures++;
      $display("FAIL straddle_read got=%h want=1200", dread_data);
    end
    dread_addr = 16'h4000;
    for (int k = 0; k < 4; k++) begin
      drive_cycle();
      e = sb_q.pop_front();
      checks++;
      if (bus_err !== 1'b1) begin
        failures++;
        $display("FAIL err_sticky cycle %0d got=%b want=1", k, bus_err);
      end
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 9) < 7) return 16'h4000 + 16'($urandom_range(0, 15));
    return 16'h40F8 + 16'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    exp_t e;
    for (int k = 0; k < 300; k++) begin
      iread_addr  = rnd_addr();
      dread_addr  = rnd_addr();
      dwrite_addr = rnd_addr();
      dwrite_data = 16'($urandom);
      dwrite_en   = 2'($urandom_range(0, 3));
      load_en     = 1'($urandom_range(0, 1));
      load_addr   = rnd_addr();
      load_data   = 8'($urandom);
      drive_cycle();
      e = sb_q.pop_front();
      checks++;
      if ({iread_data, dread_data, ivalid, bus_err} !== {e.i, e.d, e.iv, e.err}) begin
        failures++;
        $display("FAIL random cycle %0d got i=%h d=%h iv=%b err=%b want i=%h d=%h iv=%b err=%b",
                 k, iread_data, dread_data, ivalid, bus_err, e.i, e.d, e.iv, e.err);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    int low;
    idle_inputs();
    reset = 1'b1;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if ({iread_data, dread_data, ivalid, ready, bus_err} !== 43'd0) begin
      failures++;
      $display("FAIL mid_reset1 got i=%h d=%h iv=%b rdy=%b err=%b want all zero",
               iread_data, dread_data, ivalid, ready, bus_err);
    end
    reset = 1'b0;
    for (int k = 0; k < 99; k++) begin
      drive_cycle();
      e = sb_q.pop_front();
    end
    reset = 1'b1;
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if ({iread_data, dread_data, ivalid, ready, bus_err} !== 43'd0) begin
      failures++;
      $display("FAIL mid_reset2 got i=%h d=%h iv=%b rdy=%b err=%b want all zero",
               iread_data, dread_data, ivalid, ready, bus_err);
    end
    reset = 1'b0;
    low = 0;
    for (int k = 0; k < 256; k++) begin
      load_en   = (k == 50);
      load_addr = 16'h4000;
      load_data = 8'h99;
      drive_cycle();
      e = sb_q.pop_front();
      if (ready === 1'b0) low++;
    end
    load_en = 1'b0;
    checks++;
    if (low !== 255) begin
      failures++;
      $display("FAIL mid_clear_len got=%0d want=255", low);
    end
    drive_cycle();
    e = sb_q.pop_front();
    checks++;
    if (iread_data !== 24'h000000 || iread_data !== e.i || ready !== 1'b1) begin
      failures++;
      $display("FAIL init_load_dropped got i=%h rdy=%b want i=000000 rdy=1", iread_data, ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 256; k++) m_mem[k] = 8'h00;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_clear();
    test_preset_clear();
    test_load_fetch();
    test_byte_enables();
    test_forwarding();
    test_decode();
    test_random();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
